wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 27 ++
 rtl/wb_stage_load_align.sv | 43 ++++
 rtl/wb_stage.sv | 156 +++++++++++++++
 tb/tb_wb_stage.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared register-file types, write/reset levels and load funct3 encodings
// for the writeback stage.
package wb_stage_pkg;

    typedef logic [4:0]  RegAddrBus;
    typedef logic [31:0] RegBus;
    typedef logic [2:0]  ld_funct3_t;
    typedef logic [1:0]  addr_lo_t;

    localparam logic      RstEnable    = 1'b1;
    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
    localparam RegBus     ZeroWord     = 32'h0000_0000;
    localparam RegAddrBus ZeroRegAddr  = 5'd0;

    localparam ld_funct3_t FUNCT3_LB  = 3'b000;
    localparam ld_funct3_t FUNCT3_LH  = 3'b001;
    localparam ld_funct3_t FUNCT3_LW  = 3'b010;
    localparam ld_funct3_t FUNCT3_LBU = 3'b100;
    localparam ld_funct3_t FUNCT3_LHU = 3'b101;

    // x0 is hard-wired zero, so a write is only real when it targets x1..x31.
    function automatic logic writes_reg(input logic wreg, input RegAddrBus wd);
        return wreg && (wd != ZeroRegAddr);
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load-data alignment: picks the byte/half lane from the
// returned word and sign- or zero-extends it according to funct3.
module load_align
    import wb_stage_pkg::*;
(
    input  ld_funct3_t funct3,
    input  addr_lo_t   addr_lo,
    input  RegBus      word,
    output RegBus      data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    // Halfword lane ignores addr_lo[0]; misaligned halves are not split.
    always_comb begin
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = ZeroWord;
        case (funct3)
            FUNCT3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LH:  data = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LW:  data = word;
            FUNCT3_LBU: data = {24'h0, byte_sel};
            FUNCT3_LHU: data = {16'h0, half_sel};
            default:    data = ZeroWord;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results and waits for load data before
// writing the register file. Define WB_RETIRE_CNT_EN to add the retire_cnt counter.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_wreg,
    input  RegAddrBus  in_wd,
    input  RegBus      in_wdata,
    input  logic       in_is_load,
    input  ld_funct3_t in_ld_funct3,
    input  addr_lo_t   in_addr_lo,
    input  logic       mem_rsp_valid,
    input  RegBus      mem_rsp_data,
    output logic       we,
    output RegAddrBus  waddr,
    output RegBus      wdata
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] retire_cnt
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } state_e;

    state_e     state_q, state_d;

    logic       ld_wreg_q, ld_wreg_d;
    RegAddrBus  ld_wd_q, ld_wd_d;
    ld_funct3_t ld_funct3_q, ld_funct3_d;
    addr_lo_t   ld_addr_lo_q, ld_addr_lo_d;

    logic       we_q, we_d;
    RegAddrBus  waddr_q, waddr_d;
    RegBus      wdata_q, wdata_d;

    RegBus      aligned_data;
    logic       in_fire;

    assign in_ready = (state_q == IDLE) && (rst != RstEnable);
    assign in_fire  = in_valid && in_ready;

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

    load_align u_load_align (
        .funct3  (ld_funct3_q),
        .addr_lo (ld_addr_lo_q),
        .word    (mem_rsp_data),
        .data    (aligned_data)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire && in_is_load) state_d = WAIT_LD;
            WAIT_LD: if (mem_rsp_valid)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write port and load capture; idle write fields are forced to zero.
    always_comb begin
        we_d         = WriteDisable;
        waddr_d      = ZeroRegAddr;
        wdata_d      = ZeroWord;
        ld_wreg_d    = ld_wreg_q;
        ld_wd_d      = ld_wd_q;
        ld_funct3_d  = ld_funct3_q;
        ld_addr_lo_d = ld_addr_lo_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (in_is_load) begin
                        ld_wreg_d    = in_wreg;
                        ld_wd_d      = in_wd;
                        ld_funct3_d  = in_ld_funct3;
                        ld_addr_lo_d = in_addr_lo;
                    end else if (writes_reg(in_wreg, in_wd)) begin
                        we_d    = WriteEnable;
                        waddr_d = in_wd;
                        wdata_d = in_wdata;
                    end
                end
            end
            WAIT_LD: begin
                if (mem_rsp_valid && writes_reg(ld_wreg_q, ld_wd_q)) begin
                    we_d    = WriteEnable;
                    waddr_d = ld_wd_q;
                    wdata_d = aligned_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            we_q         <= WriteDisable;
            waddr_q      <= ZeroRegAddr;
            wdata_q      <= ZeroWord;
            ld_wreg_q    <= 1'b0;
            ld_wd_q      <= ZeroRegAddr;
            ld_funct3_q  <= 3'b000;
            ld_addr_lo_q <= 2'b00;
        end else begin
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            ld_wreg_q    <= ld_wreg_d;
            ld_wd_q      <= ld_wd_d;
            ld_funct3_q  <= ld_funct3_d;
            ld_addr_lo_q <= ld_addr_lo_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Every retired instruction counts, including those aimed at x0.
    logic        rsp_fire;
    logic [63:0] retire_cnt_q, retire_cnt_d;

    assign rsp_fire   = (state_q == WAIT_LD) && mem_rsp_valid;
    assign retire_cnt = retire_cnt_q;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if ((in_fire && !in_is_load) || rsp_fire) begin
            retire_cnt_d = retire_cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            retire_cnt_q <= 64'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wreg;
    logic [4:0]  in_wd;
    logic [31:0] in_wdata;
    logic        in_is_load;
    logic [2:0]  in_ld_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    // Model state: a pending load (if any) and the write expected on the port.
    bit          m_busy = 1'b0;
    logic        m_wreg;
    logic [4:0]  m_wd;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [63:0] exp_cnt;
    logic        n_we;
    logic [4:0]  n_waddr;
    logic [31:0] n_wdata;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wreg       (in_wreg),
        .in_wd         (in_wd),
        .in_wdata      (in_wdata),
        .in_is_load    (in_is_load),
        .in_ld_funct3  (in_ld_funct3),
        .in_addr_lo    (in_addr_lo),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .we            (we),
        .waddr         (waddr),
        .wdata         (wdata)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt    (retire_cnt)
`endif
    );

    // Arithmetic description of load extraction: shift the lane down, mask, extend.
    function automatic logic [31:0] ref_align(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(lo))) & 32'h0000_00FF;
        h = (w >> (16 * (int'(lo) / 2))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic wreg, input logic [4:0] wd,
                                 input logic [31:0] wd_data, input logic ld,
                                 input logic [2:0] f3, input logic [1:0] lo,
                                 input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        in_valid      = v;
        in_wreg       = wreg;
        in_wd         = wd;
        in_wdata      = wd_data;
        in_is_load    = ld;
        in_ld_funct3  = f3;
        in_addr_lo    = lo;
        mem_rsp_valid = rv;
        mem_rsp_data  = rd;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
    endtask

    // Load accepted, response in the first wait cycle, then the aligned write.
    task automatic runLoad(input string name, input logic [4:0] wd, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] rsp, input logic [31:0] expect_data);
        applyStimulus(1'b1, 1'b1, wd, 32'h0, 1'b1, f3, lo, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1, rsp);
        @(negedge clk);
        checkOutput({name, "_wait_ready"}, 64'(in_ready), 64'd0);
        checkOutput({name, "_wait_we"}, 64'(we), 64'd0);
        idleCycle();
        @(negedge clk);
        checkOutput({name, "_we"}, 64'(we), 64'd1);
        checkOutput({name, "_waddr"}, 64'(waddr), 64'(wd));
        checkOutput({name, "_wdata"}, 64'(wdata), 64'(expect_data));
        checkOutput({name, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy    = 1'b0;
            m_wreg    = 1'b0;
            m_wd      = 5'd0;
            m_f3      = 3'd0;
            m_lo      = 2'd0;
            exp_we    = 1'b0;
            exp_waddr = 5'd0;
            exp_wdata = 32'h0;
            exp_cnt   = 64'd0;
        end else begin
            n_we    = 1'b0;
            n_waddr = 5'd0;
            n_wdata = 32'h0;
            if (!m_busy) begin
                if (in_valid) begin
                    if (in_is_load) begin
                        m_busy = 1'b1;
                        m_wreg = in_wreg;
                        m_wd   = in_wd;
                        m_f3   = in_ld_funct3;
                        m_lo   = in_addr_lo;
                    end else begin
                        exp_cnt = exp_cnt + 64'd1;
                        if (in_wreg && in_wd != 5'd0) begin
                            n_we    = 1'b1;
                            n_waddr = in_wd;
                            n_wdata = in_wdata;
                        end
                    end
                end
            end else if (mem_rsp_valid) begin
                m_busy  = 1'b0;
                exp_cnt = exp_cnt + 64'd1;
                if (m_wreg && m_wd != 5'd0) begin
                    n_we    = 1'b1;
                    n_waddr = m_wd;
                    n_wdata = ref_align(m_f3, m_lo, mem_rsp_data);
                end
            end
            exp_we    = n_we;
            exp_waddr = n_waddr;
            exp_wdata = n_wdata;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("cyc_in_ready", 64'(in_ready), 64'(!m_busy && !rst));
            checkOutput("cyc_we", 64'(we), 64'(exp_we));
            checkOutput("cyc_waddr", 64'(waddr), 64'(exp_waddr));
            checkOutput("cyc_wdata", 64'(wdata), 64'(exp_wdata));
`ifdef WB_RETIRE_CNT_EN
            checkOutput("cyc_retire_cnt", retire_cnt, exp_cnt);
`endif
        end
    end

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_wreg       = 1'b0;
        in_wd         = 5'd0;
        in_wdata      = 32'h0;
        in_is_load    = 1'b0;
        in_ld_funct3  = 3'd0;
        in_addr_lo    = 2'd0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;

        @(posedge clk);
        #1;
        checking = 1'b1;
        @(negedge clk);
        checkOutput("rst_we", 64'(we), 64'd0);
        checkOutput("rst_waddr", 64'(waddr), 64'd0);
        checkOutput("rst_wdata", 64'(wdata), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("rst_retire_cnt", retire_cnt, 64'd0);
`endif
        idleCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", 64'(in_ready), 64'd1);

        checkOutput("model_lb", 64'(ref_align(3'd0, 2'd3, 32'h80FF_0000)), 64'h0000_0000_FFFF_FF80);
        checkOutput("model_lbu", 64'(ref_align(3'd4, 2'd3, 32'h80FF_0000)), 64'h0000_0000_0000_0080);
        checkOutput("model_lh", 64'(ref_align(3'd1, 2'd2, 32'h8001_1234)), 64'h0000_0000_FFFF_8001);
        checkOutput("model_bad_f3", 64'(ref_align(3'd3, 2'd0, 32'h1234_5678)), 64'd0);

        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
        idleCycle();
        @(negedge clk);
        checkOutput("alu_we", 64'(we), 64'd1);
        checkOutput("alu_waddr", 64'(waddr), 64'd5);
        checkOutput("alu_wdata", 64'(wdata), 64'h0000_0000_DEAD_BEEF);
        idleCycle();
        @(negedge clk);
        checkOutput("alu_we_drop", 64'(we), 64'd0);
        checkOutput("alu_wdata_drop", 64'(wdata), 64'd0);

        runLoad("lb", 5'd7, 3'd0, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80);
        runLoad("lbu", 5'd8, 3'd4, 2'd3, 32'h80FF_0000, 32'h0000_0080);
        runLoad("lh", 5'd10, 3'd1, 2'd2, 32'h8001_1234, 32'hFFFF_8001);

        applyStimulus(1'b1, 1'b1, 5'd0, 32'h0000_0001, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
        idleCycle();
        @(negedge clk);
        checkOutput("x0_we", 64'(we), 64'd0);
        checkOutput("x0_wdata", 64'(wdata), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("x0_retire_cnt", retire_cnt, 64'd5);
`endif

        applyStimulus(1'b1, 1'b1, 5'd9, 32'h0, 1'b1, 3'd2, 2'd0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0, 1'b1, 32'h1234_5678);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abandon_ready_in_rst", 64'(in_ready), 64'd0);
        idleCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abandon_we", 64'(we), 64'd0);
        checkOutput("abandon_ready", 64'(in_ready), 64'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("abandon_no_late_we", 64'(we), 64'd0);

        applyStimulus(1'b1, 1'b1, 5'd1, 32'h0000_0011, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 5'd2, 32'h0000_0022, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("b2b_1_we", 64'(we), 64'd1);
        checkOutput("b2b_1_waddr", 64'(waddr), 64'd1);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h0000_0033, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("b2b_2_we", 64'(we), 64'd1);
        checkOutput("b2b_2_waddr", 64'(waddr), 64'd2);
        idleCycle();
        @(negedge clk);
        checkOutput("b2b_3_we", 64'(we), 64'd1);
        checkOutput("b2b_3_waddr", 64'(waddr), 64'd3);
        checkOutput("b2b_3_wdata", 64'(wdata), 64'h33);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("b2b_retire_cnt", retire_cnt, 64'd3);
`endif
        idleCycle();

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                          $urandom,
                          1'($urandom_range(0, 4) < 2),
                          3'($urandom_range(0, 7)),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)),
                          $urandom);
            rst = ($urandom_range(0, 63) == 0);
        end
        rst = 1'b0;
        idleCycle();
        idleCycle();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
